// File: rtl/seven_seg_scan_if.sv
// Display-side bundle for seven_seg_scan: value/decimal-point requests in,
// active-low anode/segment/dp lines out.
interface seven_seg_scan_if #(
    parameter int unsigned DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic                dp;

    modport master (
        output value,
        output dp_in,
        input  an,
        input  seg,
        input  dp
    );

    modport slave (
        input  value,
        input  dp_in,
        output an,
        output seg,
        output dp
    );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment scanner with anode dead time and per-frame
// value latching. Define SEVSEG_LZB_EN to enable leading-zero blanking.
module seven_seg_scan #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned DEAD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_clk,
    seven_seg_scan_if.slave   bus
);

    localparam int unsigned           IdxW     = $clog2(DIGITS);
    localparam logic [IdxW-1:0]       LastIdx  = IdxW'(DIGITS - 1);
    localparam logic [7:0]            DeadLoad = 8'(DEAD_CYCLES);
    localparam logic [DIGITS-1:0]     AnOne    = DIGITS'(1);

    typedef enum logic [1:0] {StIdle, StDead, StDrive} state_e;

    // scan_clk is asynchronous: two sync flops, third flop for edge detection
    logic sync1_q, sync2_q, sync3_q;
    logic tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= scan_clk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign tick = sync2_q & ~sync3_q;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [7:0]          dead_q, dead_d;
    logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            idx_q        <= LastIdx;
            dead_q       <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dead_q       <= dead_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dead_d       = dead_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        if (tick) begin
            idx_d = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
            // Frame start: latch the whole display so a frame never tears
            if (idx_d == '0) begin
                shadow_val_d = bus.value;
                shadow_dp_d  = bus.dp_in;
            end
            if (DeadLoad == 8'd0) begin
                state_d = StDrive;
                dead_d  = '0;
            end else begin
                state_d = StDead;
                dead_d  = DeadLoad;
            end
        end else begin
            case (state_q)
                StIdle: ;
                StDead: begin
                    if (dead_q <= 8'd1) begin
                        state_d = StDrive;
                        dead_d  = '0;
                    end else begin
                        dead_d = dead_q - 8'd1;
                    end
                end
                StDrive: ;
                default: state_d = StIdle;
            endcase
        end
    end

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [3:0] nib_d;
    logic       blank_d;

    assign nib_d = shadow_val_d[{idx_d, 2'b00} +: 4];

`ifdef SEVSEG_LZB_EN
    logic [DIGITS-1:0] blank_mask;
    logic              zero_run;

    // Digit i blanks when it and every more-significant nibble are zero; digit 0 never does
    always_comb begin
        blank_mask = '0;
        zero_run   = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run      = zero_run & (shadow_val_d[4*i +: 4] == 4'h0);
            blank_mask[i] = zero_run;
        end
    end

    assign blank_d = blank_mask[idx_d];
`else
    assign blank_d = 1'b0;
`endif

    // Outputs are registered from next-state so they change on the same edge as the state
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    always_comb begin
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (state_d == StDrive) begin
            an_d  = ~(AnOne << idx_d);
            seg_d = blank_d ? 7'h7F : hex_to_seg(nib_d);
            dp_d  = ~shadow_dp_d[idx_d];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_q  <= '1;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomized and directed bench for seven_seg_scan, checked every cycle against a
// tick-age behavioural model, with literal expectations from the display decode table.
module tb_seven_seg_scan;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DEAD   = 4;

    logic clk      = 1'b0;
    logic reset    = 1'b0;
    logic scan_clk = 1'b0;

    seven_seg_scan_if #(.DIGITS(DIGITS)) bus ();

    seven_seg_scan #(
        .DIGITS      (DIGITS),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .scan_clk (scan_clk),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    int                  m_idx  = DIGITS - 1;
    int                  m_age  = -1;      // clk edges since the last tick, -1 = none yet
    logic [4*DIGITS-1:0] m_sh   = '0;
    logic [DIGITS-1:0]   m_shdp = '0;
    bit                  hist [$] = '{1'b0, 1'b0, 1'b0};  // scan_clk samples, newest first
    bit                  m_tick;
    logic [DIGITS-1:0]   m_an   = '1;
    logic [6:0]          m_seg  = 7'h7F;
    logic                m_dp   = 1'b1;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_idx  = DIGITS - 1;
            m_age  = -1;
            m_sh   = '0;
            m_shdp = '0;
            hist   = '{1'b0, 1'b0, 1'b0};
        end else begin
            // Edge sampled at k-2 high and at k-3 low acts at edge k
            m_tick = hist[1] && !hist[2];
            hist.push_front(scan_clk);
            void'(hist.pop_back());
            if (m_tick) begin
                m_idx = (m_idx + 1) % DIGITS;
                m_age = 0;
                if (m_idx == 0) begin
                    m_sh   = bus.value;
                    m_shdp = bus.dp_in;
                end
            end else if (m_age >= 0 && m_age < 100000) begin
                m_age++;
            end
        end
        m_an  = '1;
        m_seg = 7'h7F;
        m_dp  = 1'b1;
        if (m_age >= int'(DEAD)) begin
            logic [3:0] nib;
            logic       blank;
            nib   = m_sh[4*m_idx +: 4];
            blank = 1'b0;
`ifdef SEVSEG_LZB_EN
            if (m_idx > 0 && (m_sh >> (4*m_idx)) == 0) blank = 1'b1;
`endif
            m_an  = ~(DIGITS'(1) << m_idx);
            m_seg = blank ? 7'h7F : seg_tab[nib];
            m_dp  = ~m_shdp[m_idx];
        end
    end

    initial forever begin
        @(negedge clk);
        check("scan_out", {bus.an, bus.seg, bus.dp}, {m_an, m_seg, m_dp});
    end

    // ---------------- directed helpers ----------------
    // Called just after scan_clk rises; returns clk edges until the anode drives again
    task automatic wait_drive(output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 3) scan_clk = 1'b0;
            if (n >= 3 && bus.an != '1) break;
        end
        scan_clk = 1'b0;
    endtask

    task automatic advance(input string name);
        int n;
        @(negedge clk);
        scan_clk = 1'b1;
        wait_drive(n);
        check({name, "_lat"}, n, DEAD + 3);
    endtask

    task automatic pulse(input string name, input logic [3:0] exp_an,
                         input logic [6:0] exp_seg, input logic exp_dp);
        int n;
        @(negedge clk);
        scan_clk = 1'b1;
        wait_drive(n);
        check({name, "_lat"}, n, DEAD + 3);
        check({name, "_an"}, bus.an, exp_an);
        check({name, "_seg"}, bus.seg, exp_seg);
        check({name, "_dp"}, bus.dp, exp_dp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int n;
        bus.value = 16'h12AF;
        bus.dp_in = '0;
        repeat (3) @(negedge clk);
        check("reset_an", bus.an, 4'hF);
        check("reset_seg", bus.seg, 7'h7F);
        check("reset_dp", bus.dp, 1'b1);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_an", bus.an, 4'hF);

        // Frame order and mid-frame value change
        pulse("d0", 4'b1110, 7'b0001110, 1'b1);
        pulse("d1", 4'b1101, 7'b0001000, 1'b1);
        bus.value = 16'h0000;
        pulse("d2", 4'b1011, 7'b0100100, 1'b1);
        pulse("d3", 4'b0111, 7'b1111001, 1'b1);
        pulse("nf0", 4'b1110, 7'b1000000, 1'b1);

        // Decimal point follows the shadow, latched at frame start
        bus.value = 16'h5678;
        bus.dp_in = 4'b0100;
        advance("a1");
        advance("a2");
        advance("a3");
        pulse("dp0", 4'b1110, 7'b0000000, 1'b1);
        pulse("dp1", 4'b1101, 7'b1111000, 1'b1);
        pulse("dp2", 4'b1011, 7'b0000010, 1'b0);
        advance("a4");
        advance("a5");
        advance("a6");
        check("pre_reset_an", bus.an, 4'b1101);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("async_reset", {bus.an, bus.seg, bus.dp}, {4'hF, 7'h7F, 1'b1});
        #1 reset = 1'b1;
        pulse("rst_d0", 4'b1110, 7'b0000000, 1'b1);

        // Two ticks two cycles apart: dark until DEAD after the second, index +2
        @(negedge clk) scan_clk = 1'b1;
        @(negedge clk) scan_clk = 1'b0;
        @(negedge clk) scan_clk = 1'b1;
        wait_drive(n);
        check("dbl_lat", n, DEAD + 3);
        check("dbl_an", bus.an, 4'b1011);
        check("dbl_seg", bus.seg, 7'b0000010);

        // Leading-zero handling
        bus.value = 16'h0030;
        bus.dp_in = '0;
        advance("a7");
        pulse("lz0", 4'b1110, 7'b1000000, 1'b1);
        pulse("lz1", 4'b1101, 7'b0110000, 1'b1);
`ifdef SEVSEG_LZB_EN
        pulse("lz2", 4'b1011, 7'h7F, 1'b1);
        pulse("lz3", 4'b0111, 7'h7F, 1'b1);
`else
        pulse("lz2", 4'b1011, 7'b1000000, 1'b1);
        pulse("lz3", 4'b0111, 7'b1000000, 1'b1);
`endif

        // Randomized scan_clk timing with live value/dp churn
        for (int i = 0; i < 300; i++) begin
            int hi;
            int lo;
            hi = $urandom_range(1, 6);
            lo = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : $urandom_range(3, 12);
            scan_clk = 1'b1;
            repeat (hi) begin
                @(negedge clk);
                if ($urandom_range(0, 3) == 0) bus.value = 16'($urandom);
                if ($urandom_range(0, 7) == 0) bus.dp_in = 4'($urandom);
            end
            scan_clk = 1'b0;
            repeat (lo) begin
                @(negedge clk);
                if ($urandom_range(0, 3) == 0) bus.value = 16'($urandom);
                if ($urandom_range(0, 7) == 0) bus.dp_in = 4'($urandom);
            end
        end

        repeat (12) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed scanner for the board's common-anode seven-segment display. Consumes the divided refresh clock from the display clock divider as a sampled strobe, not as a clock. Steps through `DIGITS` digit positions, decodes one hex nibble per position, and drives active-low anode and segment lines. Adds a programmable anode dead time to suppress ghosting, and latches the displayed value once per frame to prevent tearing.

## Interface
Parameters:
- `DIGITS`, 4, number of digit positions (legal range 2–8).
- `DEAD_CYCLES`, 4, `clk` cycles with all anodes off after each digit advance (legal range 0–255).

Ports:
- `clk`  in  1  system clock; the only clock in the block.
- `reset`  in  1  asynchronous, active-low reset.
- `scan_clk`  in  1  divided refresh clock from the divider; asynchronous to `clk` for design purposes.
- `value`  in  4*DIGITS  hex digits to display; nibble i goes to digit i, and digit 0 is rightmost.
- `dp_in`  in  DIGITS  decimal-point request per digit, active-high.
- `an`  out  DIGITS  anode enables, active-low, one-hot-low while driving.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.

## Operation
- `scan_clk` passes through a 2-flop synchronizer, then a rising-edge detector on the synchronized signal. This produces `tick`, a single-cycle pulse.
- State machine states:
  - IDLE: outputs off. This is the reset state.
  - DEAD: all anodes off while the dead counter is nonzero.
  - DRIVE: the selected anode is low and `seg`/`dp` are valid.
- Transitions:
  - IDLE→DEAD on the first `tick`.
  - DEAD→DRIVE when the dead counter reaches 0. If `DEAD_CYCLES`=0, DEAD lasts 0 cycles, so a tick moves directly to DRIVE.
  - DRIVE→DEAD on `tick`.
  - DEAD→DEAD on `tick`: the dead counter reloads.
- Digit index:
  - Reset value is `DIGITS-1`.
  - Each `tick` increments the index, wrapping from `DIGITS-1` to 0.
- Frame shadow register:
  - Whenever the index advances to 0, `value` and `dp_in` are captured into a shadow register on the same edge.
  - All decoding uses the shadow register, never the live `value` or `dp_in`.
- Hex decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- `dp` = ~shadow_dp[index] during DRIVE, 1 otherwise.
- Outputs in IDLE and DEAD: `an`=all ones, `seg`=7'h7F, `dp`=1.
- Reset values:
  - `an`=all ones, `seg`=7'h7F, `dp`=1.
  - State=IDLE, index=`DIGITS-1`, shadow=0, dead counter=0.
- Reset asserted mid-frame forces the reset values immediately (asynchronously). Scanning restarts from digit 0 on the first tick after release.

## Timing
- A `scan_clk` rising edge first sampled by `clk` edge n produces `tick` high during cycle n+2. Edge detection compares sync stage 2 with its delayed copy.
- `an`, `seg`, and `dp` are registered; no combinational path exists from any input to any output.
- On the `clk` edge where `tick` is high, the index advances, the shadow loads (if applicable), and the state enters DEAD with counter=`DEAD_CYCLES`. Outputs are off from that edge onward.
- The dead counter decrements once per cycle. On the edge where it goes 1→0, the state enters DRIVE, so the anode goes low exactly `DEAD_CYCLES` cycles after the tick edge.
- Ticks closer together than `DEAD_CYCLES` keep the outputs dark. Each such tick still advances the index.
- `value` changing at any time other than the frame-start edge has no visible effect until the next frame.

## Configuration
- `SEVSEG_LZB_EN` (leading-zero blanking).
- Defined: a digit i>0 is blanked (`seg`=7'h7F) when shadow nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - The anode of a blanked digit still follows the scan.
  - `dp` remains governed by `dp_in`.
- Undefined: every digit decodes its nibble; zeros are displayed.

## Test plan
- Reset release, then 4 `scan_clk` pulses with `value`=16'h12AF, `dp_in`=0, `DEAD_CYCLES`=4:
  - Frame order is `an`=1110/`seg`=0001110, then 1101/0001000, then 1011/0100100, then 0111/1111001.
  - Each anode goes low exactly 4 `clk` cycles after its tick.
- Mid-frame `value` change (16'h12AF→16'h0000 while digit 1 is displayed): digits 2 and 3 still show 2 and 1. The next frame shows 0 on all digits (macro off).
- With `SEVSEG_LZB_EN`, `value`=16'h0030:
  - Digits 3 and 2 show `seg`=7'h7F while their anodes are low.
  - Digit 1 shows 0110000; digit 0 shows 1000000.
- `dp_in`=4'b0100: `dp`=0 only while `an`=1011; otherwise `dp`=1.
- Async reset pulsed low while `an`=1101: outputs go to all-off in the same cycle without a `clk` edge. After release, the first tick selects digit 0.
- Two ticks 2 cycles apart with `DEAD_CYCLES`=4: the outputs stay dark until 4 cycles after the second tick, and the index has advanced by 2.
